uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (start_tx/data_tx/idle_ready_tx) between N byte-stream requesters
//  (threshold echo, telemetry reporter, alarm notifier). Requests are served round-robin. Grants are

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encodings,
// byte and statistics-counter widths, and a saturating increment helper.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int TCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    HOLDOFF   = 3'd2,
    WAIT_IDLE = 3'd3,
    STALL     = 3'd4
  } arb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the lowest requesting index at or
// after ptr, wrapping past N_REQ-1 back to 0.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             grant_valid,
  output logic [PW-1:0]    grant_idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the candidate closest to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among N_REQ
// byte-stream requesters. The owner keeps the transmitter until a byte flagged
// last is sent, or until it leaves req low mid-packet for LOCK_TIMEOUT cycles.
// Optional build macro UART_ARB_TIMEOUT_STATS_EN enables the revoked-lock
// counter on timeout_count; otherwise that output is tied to zero.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int LOCK_TIMEOUT   = 1000,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [BYTE_W*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         ack,
  input  logic                     idle_ready_tx,
  output logic                     start_tx,
  output logic [BYTE_W-1:0]        data_tx,
  output logic                     busy,
  output logic [PW-1:0]            owner,
  output logic [TCNT_W-1:0]        timeout_count
);

  localparam int         TW        = $clog2(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LIM = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYCLES - 1);

  arb_state_t        state_reg;
  logic [PW-1:0]     ptr_reg;
  logic [BYTE_W-1:0] byte_reg;
  logic              last_reg;
  logic [3:0]        hold_reg;
  logic [TW-1:0]     timer_reg;

  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     owner_inc;
  logic              revoke;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
    assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
  end

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req         (req),
    .ptr         (ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
  assign revoke    = (state_reg == STALL) && !req[owner] && (timer_reg == TIMER_LIM);

  // Arbitration / byte-issue FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner     <= '0;
      start_tx  <= 1'b0;
      data_tx   <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      byte_reg  <= '0;
      last_reg  <= 1'b0;
      hold_reg  <= '0;
      timer_reg <= '0;
    end else begin
      start_tx <= 1'b0;
      ack      <= '0;
      case (state_reg)
        IDLE: begin
          // The uart may still be finishing a byte after a reset, so wait for idle.
          if (grant_valid && idle_ready_tx) begin
            owner     <= grant_idx;
            busy      <= 1'b1;
            byte_reg  <= req_bytes[grant_idx];
            last_reg  <= req_last[grant_idx];
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          start_tx   <= 1'b1;
          data_tx    <= byte_reg;
          ack[owner] <= 1'b1;
          hold_reg   <= HOLD_INIT;
          state_reg  <= HOLDOFF;
        end
        HOLDOFF: begin
          // The uart may not have dropped idle yet; ignore it for a while.
          if (hold_reg == '0) begin
            state_reg <= WAIT_IDLE;
          end else begin
            hold_reg <= hold_reg - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (idle_ready_tx) begin
            if (last_reg) begin
              ptr_reg   <= owner_inc;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else if (req[owner]) begin
              byte_reg  <= req_bytes[owner];
              last_reg  <= req_last[owner];
              state_reg <= ISSUE;
            end else begin
              timer_reg <= '0;
              state_reg <= STALL;
            end
          end
        end
        STALL: begin
          if (req[owner]) begin
            byte_reg  <= req_bytes[owner];
            last_reg  <= req_last[owner];
            state_reg <= ISSUE;
          end else if (revoke) begin
            ptr_reg   <= owner_inc;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_STATS_EN
  logic [TCNT_W-1:0] tcnt_reg;

  // Count revoked locks, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg <= '0;
    end else if (revoke) begin
      tcnt_reg <= sat_inc(tcnt_reg);
    end
  end

  assign timeout_count = tcnt_reg;
`else
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// packet traffic compared against a queue-based round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int LT = 8;
`ifdef UART_ARB_TIMEOUT_STATS_EN
  localparam int EXP_TO = 1;
`else
  localparam int EXP_TO = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic        idle_ready_tx = 1'b1;
  logic [2:0]  ack;
  logic        start_tx;
  logic [7:0]  data_tx;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] timeout_count;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .HOLDOFF_CYCLES(2), .LOCK_TIMEOUT(LT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .ack           (ack),
    .idle_ready_tx (idle_ready_tx),
    .start_tx      (start_tx),
    .data_tx       (data_tx),
    .busy          (busy),
    .owner         (owner),
    .timeout_count (timeout_count)
  );

  int n_pass = 0;
  int n_checks = 0;

  // UART model: idle stays high for uart_lag cycles after start_tx, then low for byte_time cycles.
  int  uart_lag = 0;
  int  byte_time = 4;
  bit  uart_rand = 0;
  int  lag_c = 0;
  int  busy_c = 0;
  int  overlap = 0;

  initial begin
    int l, b;
    forever begin
      @(negedge clk);
      if (start_tx) begin
        if (lag_c > 0 || busy_c > 0) overlap++;
        l = uart_rand ? int'($urandom_range(0, 2)) : uart_lag;
        b = uart_rand ? int'($urandom_range(1, 6)) : byte_time;
        lag_c = l;
        busy_c = b;
        if (lag_c == 0) idle_ready_tx = 1'b0;
      end else if (lag_c > 0) begin
        lag_c--;
        if (lag_c == 0) idle_ready_tx = 1'b0;
      end else if (busy_c > 0) begin
        busy_c--;
        if (busy_c == 0) idle_ready_tx = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_data[8*i +: 8] = d;
    req_last[i] = l;
    req[i] = 1'b1;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (start_tx) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && idle_ready_tx) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_quiet"}, 32'(ok), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input int idx, input logic [7:0] d);
    bit ok;
    wait_start(200, ok);
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_data"}, 32'(data_tx), 32'(d));
      chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
      chk({tag, "_owner"}, 32'(owner), 32'(idx));
      $display("tx: %s owner=%0d data=%02h", tag, owner, data_tx);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'({start_tx, ack}), 32'd0);
    end
  endtask

  // Randomized traffic storage and reference model
  logic [7:0] rb [3][16];
  bit         rl [3][16];
  int         rn [3];
  int         exp_i [$];
  logic [7:0] exp_b [$];

  task automatic present(input int i, input int p);
    if (p < rn[i]) begin
      req_data[8*i +: 8] = rb[i][p];
      req_last[i] = rl[i][p];
      req[i] = 1'b1;
    end else begin
      req[i] = 1'b0;
    end
  endtask

  task automatic random_round();
    int mpos [3];
    int pos [3];
    int gapc [3];
    int ptr_m, w, total, got, e_i;
    logic [7:0] e_b;
    bit done;
    // build packets: 2..4 packets of 1..3 bytes per requester
    for (int i = 0; i < 3; i++) begin
      int np, len;
      rn[i] = 0;
      np = $urandom_range(2, 4);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          rb[i][rn[i]] = 8'($urandom);
          rl[i][rn[i]] = (j == len - 1);
          rn[i]++;
        end
      end
      mpos[i] = 0;
    end
    // reference: whole packets, round-robin among requesters with packets left
    exp_i.delete();
    exp_b.delete();
    ptr_m = 0;
    for (int step = 0; step < 100; step++) begin
      w = -1;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (ptr_m + k) % 3;
        if (w < 0 && mpos[c] < rn[c]) w = c;
      end
      if (w < 0) break;
      done = 0;
      while (!done) begin
        exp_i.push_back(w);
        exp_b.push_back(rb[w][mpos[w]]);
        done = rl[w][mpos[w]];
        mpos[w]++;
      end
      ptr_m = (w + 1) % 3;
    end
    total = exp_i.size();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      gapc[i] = 0;
      present(i, 0);
    end
    got = 0;
    for (int cyc = 0; cyc < 20000 && got < total; cyc++) begin
      @(negedge clk);
      if (start_tx) begin
        if (exp_i.size() > 0) begin
          e_i = exp_i.pop_front();
          e_b = exp_b.pop_front();
          chk("rand_ack", 32'(ack), 32'(1) << e_i);
          chk("rand_data", 32'(data_tx), 32'(e_b));
        end
        $display("rand tx: byte %0d owner=%0d data=%02h", got, owner, data_tx);
        got++;
      end
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          pos[i]++;
          if (!rl[i][pos[i]-1] && $urandom_range(0, 1) == 1) begin
            req[i] = 1'b0;
            gapc[i] = $urandom_range(1, 3);
          end else begin
            present(i, pos[i]);
          end
        end else if (gapc[i] > 0) begin
          gapc[i]--;
          if (gapc[i] == 0) present(i, pos[i]);
        end
      end
    end
    chk("rand_count", 32'(got), 32'(total));
    req = '0;
    wait_quiet("rand_end");
  endtask

  initial begin
    bit ok;
    int gap, low, cnt, bad;

    // Reset values
    do_reset();
    chk("rst_start", 32'(start_tx), 32'd0);
    chk("rst_data", 32'(data_tx), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_tcnt", 32'(timeout_count), 32'd0);

    // 1: all three single-byte requesters, grants 0,1,2,0
    set_req(0, 8'hA0, 1'b1);
    set_req(1, 8'hA1, 1'b1);
    set_req(2, 8'hA2, 1'b1);
    for (int k = 0; k < 4; k++) expect_byte("t1", k % 3, 8'hA0 + 8'(k % 3));
    req = '0;
    wait_quiet("t1");

    // 6: ptr=1 with only req2 -> 2; then req 0 and 1 -> 0 after wrap
    do_reset();
    set_req(0, 8'h10, 1'b1);
    expect_byte("t6a", 0, 8'h10);
    req[0] = 1'b0;
    wait_quiet("t6a");
    set_req(2, 8'h12, 1'b1);
    expect_byte("t6b", 2, 8'h12);
    req[2] = 1'b0;
    wait_quiet("t6b");
    set_req(0, 8'h20, 1'b1);
    set_req(1, 8'h21, 1'b1);
    expect_byte("t6c", 0, 8'h20);
    req = '0;
    wait_quiet("t6c");

    // 2: req1 two-byte packet 09,F6 locks out req0
    do_reset();
    set_req(0, 8'h11, 1'b1);
    expect_byte("t2pre", 0, 8'h11);
    req[0] = 1'b0;
    wait_quiet("t2pre");
    set_req(1, 8'h09, 1'b0);
    set_req(0, 8'h55, 1'b1);
    expect_byte("t2b0", 1, 8'h09);
    req_data[15:8] = 8'hF6;
    req_last[1] = 1'b1;
    expect_byte("t2b1", 1, 8'hF6);
    req[1] = 1'b0;
    low = 0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (start_tx) begin
        ok = 1;
        break;
      end
      if (!busy) low++;
    end
    chk("t2_seen", 32'(ok), 32'd1);
    chk("t2_busy_gap", 32'(low), 32'd1);
    chk("t2_data", 32'(data_tx), 32'h55);
    chk("t2_ack", 32'(ack), 32'd1);
    req = '0;
    wait_quiet("t2");

    // 3: uart keeps idle high 2 cycles after start_tx; holdoff must hide it.
    // Next launch: idle rises lag+byte_time+1 edges after the pulse, then IDLE and ISSUE add 2.
    do_reset();
    uart_lag = 2;
    byte_time = 4;
    set_req(0, 8'h33, 1'b1);
    wait_start(200, ok);
    chk("t3_first", 32'(ok), 32'd1);
    gap = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      gap++;
      if (start_tx) break;
    end
    chk("t3_gap", 32'(gap), 32'(2 + 4 + 3));
    req = '0;
    wait_quiet("t3");
    uart_lag = 0;

    // 4: owner drops req mid-packet -> revocation after LOCK_TIMEOUT stall cycles
    do_reset();
    set_req(0, 8'h40, 1'b0);
    set_req(2, 8'h42, 1'b1);
    expect_byte("t4a", 0, 8'h40);
    req[0] = 1'b0;
    for (int k = 0; k < 100 && !idle_ready_tx; k++) @(negedge clk);
    chk("t4_idle", 32'(idle_ready_tx), 32'd1);
    cnt = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      cnt++;
      @(negedge clk);
    end
    // one WAIT_IDLE edge sees idle, then LT stall cycles
    chk("t4_busy_len", 32'(cnt), 32'(LT + 1));
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_tcnt", 32'(timeout_count), 32'(EXP_TO));
    set_req(0, 8'h43, 1'b1);
    expect_byte("t4b", 2, 8'h42);
    req[2] = 1'b0;
    expect_byte("t4c", 0, 8'h43);
    req = '0;
    wait_quiet("t4");

    // 5: reset during WAIT_IDLE of a multi-byte packet
    do_reset();
    byte_time = 8;
    set_req(0, 8'h50, 1'b1);
    expect_byte("t5pre", 0, 8'h50);
    req[0] = 1'b0;
    wait_quiet("t5pre");
    set_req(1, 8'h71, 1'b0);
    expect_byte("t5a", 1, 8'h71);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 8'h60, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_start", 32'(start_tx), 32'd0);
    chk("t5_data", 32'(data_tx), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_tcnt", 32'(timeout_count), 32'd0);
    bad = 0;
    for (int k = 0; k < 100 && !idle_ready_tx; k++) begin
      if (start_tx) bad++;
      @(negedge clk);
    end
    chk("t5_no_early", 32'(bad), 32'd0);
    expect_byte("t5b", 0, 8'h60);
    req = '0;
    wait_quiet("t5");
    byte_time = 4;

    // Randomized packets against the round-robin packet model
    uart_rand = 1;
    for (int r = 0; r < 3; r++) random_round();
    uart_rand = 0;
    chk("uart_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
